mul_sequencer: RTL and testbench

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer.sv | 92 +++++++++
 tb/tb_mul_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add sequential multiplier that borrows an external WIDTH-bit adder.
// Ports: clock/clear (async active-high); start, op_a, op_b, signed_mode request a multiply;
// add_a/add_b/add_sum form the shared adder loop; busy/done report progress;
// result_hi/result_lo carry the 2*WIDTH product.
// Define MUL_SIGNED_EN to honour signed_mode (magnitude multiply plus a final negate cycle).
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] hi, mplier, mcand, mag_a, mag_b;
  logic [CW-1:0] cnt;
  logic fix, neg, carry;
`ifdef MUL_SIGNED_EN
  assign mag_a = (signed_mode && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (signed_mode && op_b[WIDTH-1]) ? -op_b : op_b;
  assign neg = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign mag_a = op_a;
  assign mag_b = op_b;
  assign neg = 1'b0;
`endif
  assign add_a = (state == ITER) ? hi : '0;
  assign add_b = (state == ITER && mplier[0]) ? mcand : '0;
  // The external adder only returns WIDTH bits, so rebuild its carry-out from the MSBs.
  assign carry = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                 ((add_a[WIDTH-1] | add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);
  // The product accumulates in {hi, mplier}; its halves are the result between operations.
  assign result_hi = hi;
  assign result_lo = mplier;
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      hi     <= '0;
      mplier <= '0;
      mcand  <= '0;
      cnt    <= '0;
      fix    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            hi     <= '0;
            cnt    <= '0;
            fix    <= neg;
            busy   <= 1'b1;
            state  <= ITER;
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          {hi, mplier} <= {carry, add_sum, mplier[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= fix ? FIX : DONE;
            busy  <= fix;
            done  <= ~fix;
          end
        end
        FIX: begin
          {hi, mplier} <= -{hi, mplier};
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: self-checking bench for mul_sequencer with an ideal adder in the loop.
module tb_mul_sequencer;
  localparam int W = 32;
`ifdef MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif
  logic clock = 1'b0, clear = 1'b0, start = 1'b0, signed_mode = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0, add_a, add_b, add_sum, result_hi, result_lo;
  logic busy, done;
  int n_chk = 0, n_fail = 0;
  logic [W-1:0] ghi, glo;
  int glat, gbusy, dcount;
  logic [63:0] prod;
  typedef struct {
    logic [W-1:0] a, b;
    bit sm;
    logic [W-1:0] hi, lo;
    int lat;
  } vec_t;
  vec_t v[9];

  mul_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .start(start), .op_a(op_a), .op_b(op_b),
    .signed_mode(signed_mode), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo)
  );

  always #5 clock = ~clock;
  assign add_sum = add_a + add_b;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    longint sa, sb;
    if (SIGNED_EN && sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Edges counted from the accepting edge (edge 1) to the edge after which done is seen.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    return (SIGNED_EN && sm && (a[W-1] ^ b[W-1])) ? 34 : 33;
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm);
    @(negedge clock);
    op_a = a;
    op_b = b;
    signed_mode = sm;
    start = 1'b1;
  endtask

  // With scramble set, start and operands are randomised while busy to show they are ignored.
  task automatic collect(input bit scramble);
    @(posedge clock);
    #1;
    glat = 1;
    gbusy = 0;
    if (scramble) start = 1'b0;
    while (!done && glat < 200) begin
      gbusy += int'(busy);
      if (scramble) begin
        op_a = $urandom;
        op_b = $urandom;
        signed_mode = 1'($urandom);
        start = 1'($urandom);
      end
      @(posedge clock);
      #1;
      glat++;
    end
    if (scramble) start = 1'b0;
    ghi = result_hi;
    glo = result_lo;
  endtask

  task automatic run_check(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit sm, input logic [W-1:0] ehi, input logic [W-1:0] elo, input int elat);
    launch(a, b, sm);
    collect(1'b1);
    chk({name, " hi"}, ghi, ehi);
    chk({name, " lo"}, glo, elo);
    chk({name, " latency"}, glat, elat);
    chk({name, " busy cycles"}, gbusy, elat - 1);
    @(posedge clock);
    #1;
    chk({name, " done pulse width"}, done, 0);
    chk({name, " result held"}, {result_hi, result_lo}, {ehi, elo});
    chk({name, " adder idle"}, {add_a, add_b}, 64'd0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " busy"}, busy, 0);
    chk({name, " done"}, done, 0);
    chk({name, " result"}, {result_hi, result_lo}, 64'd0);
    chk({name, " adder"}, {add_a, add_b}, 64'd0);
  endtask

  initial begin
    v[0] = '{32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 33};
    v[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 33};
    v[2] = '{32'd0, 32'h12345678, 1'b0, 32'd0, 32'd0, 33};
    v[3] = '{32'd1, 32'hDEADBEEF, 1'b0, 32'd0, 32'hDEADBEEF, 33};
    v[4] = SIGNED_EN ? '{32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 34}
                     : '{32'hFFFFFFFD, 32'd5, 1'b1, 32'h00000004, 32'hFFFFFFF1, 33};
    v[5] = '{32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'd0, 33};
    v[6] = SIGNED_EN ? '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'd0, 32'd1, 33}
                     : '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'd1, 33};
    v[7] = SIGNED_EN ? '{32'h80000000, 32'd1, 1'b1, 32'hFFFFFFFF, 32'h80000000, 34}
                     : '{32'h80000000, 32'd1, 1'b1, 32'd0, 32'h80000000, 33};
    v[8] = '{32'hFFFFFFFD, 32'd5, 1'b0, 32'h00000004, 32'hFFFFFFF1, 33};

    #2 clear = 1'b1;
    #1 chk_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock) clear = 1'b0;

    for (int i = 0; i < 9; i++)
      run_check($sformatf("vec%0d", i), v[i].a, v[i].b, v[i].sm, v[i].hi, v[i].lo, v[i].lat);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      bit sm;
      a = (i % 4 == 0) ? W'($urandom_range(0, 20)) : $urandom;
      b = (i % 5 == 0) ? {1'b1, 31'($urandom)} : $urandom;
      sm = 1'($urandom);
      prod = ref_prod(a, b, sm);
      run_check($sformatf("rand%0d", i), a, b, sm, prod[63:32], prod[31:0], ref_lat(a, b, sm));
    end

    launch(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 clear = 1'b1;
    #1 chk_zero("clear mid-op");
    @(negedge clock) clear = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(posedge clock);
      #1 dcount += int'(done);
    end
    chk("clear no done", dcount, 0);
    @(negedge clock) clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    op_a = 32'd2;
    op_b = 32'd3;
    signed_mode = 1'b0;
    start = 1'b1;
    collect(1'b1);
    chk("after clear lo", glo, 32'd6);
    chk("after clear hi", ghi, 32'd0);
    chk("after clear latency", glat, 33);

    launch(32'd7, 32'd7, 1'b0);
    collect(1'b0);
    chk("b2b first lo", glo, 32'd49);
    chk("b2b first latency", glat, 33);
    op_a = 32'd9;
    op_b = 32'd9;
    collect(1'b0);
    start = 1'b0;
    chk("b2b second lo", glo, 32'd81);
    chk("b2b second hi", ghi, 32'd0);
    chk("b2b second latency", glat, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
